// File: rtl/sprite_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sprite_line_buffer : double-banked sprite line buffer, priority compositing,
// clear-on-read. Option macro: SPRITE_LINE_BUFFER_INIT_CLEAR_EN. Rev 1.0
// ----------------------------------------------------------------------------
module sprite_line_buffer #(
    parameter int WIDTH  = 288,
    parameter int PIX_W  = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk_48m,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              wr_en,
    input  logic [8:0]        wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [PRIO_W-1:0] wr_prio,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_opaque,
    output logic              busy
);
    localparam logic [8:0] WIDTH_A = 9'(WIDTH);

    logic [PIX_W-1:0]  mem_pix  [2][WIDTH];
    logic [PRIO_W-1:0] mem_prio [2][WIDTH];

    logic              hblank_q;
    logic              bank_sel_q;
    logic              active_q;
    logic [8:0]        cnt_q, cnt_d;
    logic [PIX_W-1:0]  pix_data_q;
    logic              pix_opaque_q;

    logic              s1_vld_q;
    logic              s1_bank_q;
    logic [8:0]        s1_addr_q;
    logic [PIX_W-1:0]  s1_data_q;
    logic [PRIO_W-1:0] s1_prio_q;
    logic [PIX_W-1:0]  s1_old_pix_q, old_pix_d;
    logic [PRIO_W-1:0] s1_old_prio_q, old_prio_d;

    logic              busy_w;
    logic              rise, fall, rd_en, wr_take, wr_bank, s2_acc, fwd;
    logic [8:0]        rd_idx;
    logic [PIX_W-1:0]  rd_pix;

`ifdef SPRITE_LINE_BUFFER_INIT_CLEAR_EN
    logic              busy_q;
    logic              sweep_bank_q;
    logic [8:0]        sweep_addr_q;

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b1;
            sweep_bank_q <= 1'b0;
            sweep_addr_q <= '0;
        end else if (busy_q) begin
            if (sweep_addr_q == WIDTH_A - 9'd1) begin
                sweep_addr_q <= '0;
                sweep_bank_q <= 1'b1;
                if (sweep_bank_q) busy_q <= 1'b0;
            end else begin
                sweep_addr_q <= sweep_addr_q + 9'd1;
            end
        end
    end

    assign busy_w = busy_q;
`else
    assign busy_w = 1'b0;
`endif

    always_comb begin
        rise    = hblank & ~hblank_q;
        fall    = ~hblank & hblank_q;
        rd_idx  = fall ? 9'd0 : cnt_q;
        rd_en   = pix_ce & ~hblank & (active_q | fall) & (rd_idx < WIDTH_A) & ~busy_w;
        rd_pix  = rd_en ? mem_pix[bank_sel_q][rd_idx] : '0;

        cnt_d = cnt_q;
        if (fall)       cnt_d = rd_en ? 9'd1 : 9'd0;
        else if (rd_en) cnt_d = cnt_q + 9'd1;

        wr_take = wr_en & ~busy_w & (wr_addr < WIDTH_A) & (wr_data != '0);
        wr_bank = ~bank_sel_q;
        s2_acc  = s1_vld_q & ((s1_old_pix_q == '0) | (s1_prio_q >= s1_old_prio_q));
        // Stage 2 commits at this edge, so its result must replace the stale memory read.
        fwd     = s2_acc & (s1_bank_q == wr_bank) & (s1_addr_q == wr_addr);

        old_pix_d  = '0;
        old_prio_d = '0;
        if (fwd) begin
            old_pix_d  = s1_data_q;
            old_prio_d = s1_prio_q;
        end else if (wr_take) begin
            old_pix_d  = mem_pix[wr_bank][wr_addr];
            old_prio_d = mem_prio[wr_bank][wr_addr];
        end
    end

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            hblank_q      <= 1'b0;
            bank_sel_q    <= 1'b0;
            active_q      <= 1'b0;
            cnt_q         <= '0;
            pix_data_q    <= '0;
            pix_opaque_q  <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_bank_q     <= 1'b0;
            s1_addr_q     <= '0;
            s1_data_q     <= '0;
            s1_prio_q     <= '0;
            s1_old_pix_q  <= '0;
            s1_old_prio_q <= '0;
        end else begin
            hblank_q <= hblank;
            if (rise) bank_sel_q <= ~bank_sel_q;
            if (fall) active_q   <= 1'b1;
            cnt_q <= cnt_d;

            // A displayed dot holds until the next pixel enable or blanking.
            if (rd_en) begin
                pix_data_q   <= vblank ? '0 : rd_pix;
                pix_opaque_q <= ~vblank & (rd_pix != '0);
            end else if (pix_ce | hblank | busy_w) begin
                pix_data_q   <= '0;
                pix_opaque_q <= 1'b0;
            end

            s1_vld_q <= wr_take;
            if (wr_take) begin
                s1_bank_q     <= wr_bank;
                s1_addr_q     <= wr_addr;
                s1_data_q     <= wr_data;
                s1_prio_q     <= wr_prio;
                s1_old_pix_q  <= old_pix_d;
                s1_old_prio_q <= old_prio_d;
            end
        end
    end

    always_ff @(posedge clk_48m) begin
        if (rd_en) begin
            mem_pix[bank_sel_q][rd_idx]  <= '0;
            mem_prio[bank_sel_q][rd_idx] <= '0;
        end
        if (s2_acc) begin
            mem_pix[s1_bank_q][s1_addr_q]  <= s1_data_q;
            mem_prio[s1_bank_q][s1_addr_q] <= s1_prio_q;
        end
`ifdef SPRITE_LINE_BUFFER_INIT_CLEAR_EN
        if (busy_q) begin
            mem_pix[sweep_bank_q][sweep_addr_q]  <= '0;
            mem_prio[sweep_bank_q][sweep_addr_q] <= '0;
        end
`endif
    end

    assign pix_data   = pix_data_q;
    assign pix_opaque = pix_opaque_q;
    assign busy       = busy_w;

endmodule
`default_nettype wire

// File: doc/sprite_line_buffer.md
SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 Parameter WIDTH, default 288, visible pixels per line and entries per bank.
REQ-002 Parameter PIX_W, default 8, pixel (palette index) width; value 0 is transparent.
REQ-003 Parameter PRIO_W, default 3, sprite priority width.
REQ-004 One clock, clk_48m; reset is rst_n, asynchronous, active-low.
REQ-005 clk_48m  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pix_ce  in  1  pixel-clock enable, one clk_48m cycle wide, 6 MHz rate.
REQ-008 hblank  in  1  horizontal blank from the timing generator, active-high.
REQ-009 vblank  in  1  vertical blank from the timing generator, active-high.
REQ-010 wr_en  in  1  sprite pixel write strobe, any clk_48m cycle.
REQ-011 wr_addr  in  9  horizontal position of the write.
REQ-012 wr_data  in  PIX_W  sprite pixel; 0 never written.
REQ-013 wr_prio  in  PRIO_W  priority of the written pixel.
REQ-014 pix_data  out  PIX_W  composited sprite pixel for the current dot.
REQ-015 pix_opaque  out  1  high when pix_data is a non-transparent displayed pixel.
REQ-016 busy  out  1  high while the init sweep runs; writes are ignored while high.

Function
REQ-017 Two banks of WIDTH entries {pixel, prio}; bank_sel selects the read bank, the other bank is the write bank.
REQ-018 Bank swap (bank_sel toggles) in the clk_48m cycle after a hblank 0->1 transition is detected.
REQ-019 A write in the swap cycle targets the pre-swap write bank.
REQ-020 Read counter clears to 0 on hblank 1->0 and increments on each pix_ce while hblank is low, saturating at WIDTH.
REQ-021 On each pix_ce with hblank low and counter < WIDTH: read entry, drive pix_data/pix_opaque one clk_48m cycle later, and write {0,0} back to that entry (clear-on-read).
REQ-022 Counter = WIDTH or hblank high: pix_data = 0, pix_opaque = 0, no clear.
REQ-023 vblank high: pix_opaque forced 0 and pix_data 0; clear-on-read still occurs.
REQ-024 Write pipeline of two stages: read stored entry, then write {wr_data, wr_prio} if stored pixel is 0 or wr_prio >= stored prio; otherwise discard.
REQ-025 Back-to-back writes to the same address SHALL forward the stage-2 result into the compare; the last qualifying write wins.
REQ-026 wr_addr >= WIDTH or wr_data = 0: write discarded.
REQ-027 An accepted write is visible to a subsequent read no earlier than 2 cycles after wr_en, after the next swap.

Reset
REQ-028 On rst_n low: bank_sel 0, read counter 0, pipeline flushed, pix_data 0, pix_opaque 0, busy 0 (busy 1 if the init sweep is enabled).
REQ-029 Reset mid-line discards in-flight writes; operation resumes at the next hblank 1->0.

Configuration
REQ-030 Macro SPRITE_LINE_BUFFER_INIT_CLEAR_EN defined: after reset release, the block writes {0,0} to all 2*WIDTH entries, one per cycle, with busy high; reads output 0 during the sweep.
REQ-031 Macro undefined: no sweep, busy tied 0, and memory contents are undefined until each bank has been read once.

Verification
REQ-032 Write 0x15 prio 2 at addr 10, then hblank pulse, then active line -> pix_data 0x15, pix_opaque 1 at dot 10 only, 0 elsewhere.
REQ-033 Write 0x20 prio 3 then 0x30 prio 1 at addr 5, back-to-back -> dot 5 shows 0x20; reversed order -> 0x30 is replaced by 0x20.
REQ-034 Write 0x44 prio 4 twice at addr 7 on consecutive cycles with equal priority -> second write wins; dot 7 shows 0x44, no X.
REQ-035 Line displayed, then next line with no writes -> every dot outputs 0 and pix_opaque 0 (clear-on-read verified).
REQ-036 Write at addr 288 and 0x00 at addr 0 -> both discarded; hblank low for 300 dots -> dots 288..299 output 0.
REQ-037 Assert rst_n low mid-line, then release -> outputs 0; with the init-clear macro, busy is high for 576 cycles, then all dots read 0.
